sounder_seq_ctrl: RTL and testbench
===================================

// Module: sounder_seq_ctrl
// PURPOSE
//  Programmable sounder sequencer: decodes the configuration bus and runs an IDLE/RUN
//  state machine that emits chip-rate transmit/reference strobes, per-period sum strobes,
//  per-channel receive strobes and end-of-average dump strobes. Sits between the serial
//  configuration bus and the LFSR transmitter and correlator/integrator channels.
//  Generalises the fixed half-rate sounder controller with a programmable chip divider,
//  averaging count, channel count and shadowed (glitch-free) reconfiguration.
// PARAMETERS
//  PHASE_W    16      width of the chip phase counter and len_i
//  CHAN       2       number of receive channels (1..8)
//  BASE_ADDR  7'd64   config address of register 0; registers occupy BASE_ADDR+0..+5
// PORTS
//  clk_i         in   1        master clock, 64 MHz
//  rst_i         in   1        asynchronous active-high reset
//  saddr_i       in   7        configuration bus address
//  sdata_i       in   32       configuration bus data
//  s_strobe_i    in   1        configuration bus write strobe
//  len_i         in   PHASE_W  sequence length minus 1, from the LFSR constants table
//  reset_o       out  1        mode bit 0: datapath reset request
//  transmit_o    out  1        mode bit 1: transmitter enable
//  receive_o     out  1        mode bit 2: receiver enable
//  loopback_o    out  1        mode bit 3: digital loopback
//  degree_o      out  5        active LFSR degree (shadowed)
//  ampl_o        out  14       transmit amplitude (immediate)
//  tx_strobe_o   out  1        one-cycle chip strobe
//  ref_strobe_o  out  1        chip strobe, suppressed on the last chip of each period
//  sum_strobe_o  out  1        one cycle at the last chip of each period
//  rx_strobe_o   out  CHAN     registered sum strobe, gated per channel by the enable mask
//  dump_strobe_o out  1        one cycle when AVG periods have completed
//  busy_o        out  1        high in RUN
//  ts_o          out  32       dump timestamp (see CONFIGURATION)
// BEHAVIOUR
//  Registers: +0 mode[3:0], +1 degree[4:0], +2 ampl[13:0], +3 div[7:0], +4 avg[15:0],
//   +5 chan_en[CHAN-1:0]. A write takes effect the cycle after s_strobe_i with a matching
//   address; unused data bits are ignored.
//  Reset: all registers, counters and outputs are 0; the FSM is in IDLE.
//  Shadowing: degree, div and avg load into their active copies on entry to RUN and on
//   each sum_strobe_o. ampl, mode and chan_en apply immediately.
//  IDLE -> RUN when (transmit_o|receive_o) & ~reset_o. On entry: div_cnt=0, phase=0,
//   per_cnt=0.
//  RUN -> IDLE when reset_o=1 or transmit_o=receive_o=0. All strobes drop in the same
//   cycle; counters clear.
//  Chip timing in RUN: div_cnt counts 0..div and wraps; tx_strobe_o=(div_cnt==div).
//   div=0 gives a strobe every clock; div=1 gives the legacy half rate.
//  phase advances on tx_strobe_o. On phase==len_i with tx_strobe_o, phase wraps to 0 and
//   sum_strobe_o=1. len_i=0 gives a sum strobe on every chip.
//  ref_strobe_o = tx_strobe_o & (phase!=len_i).
//  rx_strobe_o[k] = sum_strobe_o delayed by 1 clock, & chan_en[k].
//  per_cnt increments on sum_strobe_o. Reaching max(avg,1) makes dump_strobe_o=1 in the
//   same cycle as that sum_strobe_o and clears per_cnt.
//  len_i is sampled combinationally. A change mid-period takes effect at the next compare.
//  Output strobes are combinational from registered state (0 cycles latency from the
//   counter), except rx_strobe_o, which has 1 cycle.
// CONFIGURATION
//  SOUNDER_TIMESTAMP_EN defined:
//   - a 32-bit free-running clock counter, cleared only by rst_i and wrapping at 2^32-1;
//   - ts_o latches the counter value on each dump_strobe_o cycle and holds it until the
//     next dump.
//  Undefined: ts_o is tied to 32'h0 and no counter is built.
// TESTING
//  - div=1, len_i=6, avg=1, mode=4'b0010: tx_strobe every 2nd clk; sum_strobe and dump
//    every 14 clks; ref_strobe count = 6 per period.
//  - div=0, len_i=0, avg=3, chan_en=2'b10: sum_strobe every clk; dump every 3rd;
//    rx_strobe_o=2'b10 one clk after each sum.
//  - Write div=4 mid-period (phase=3, len_i=9): the current period keeps the old div; the
//    first chip after sum_strobe uses a 5-clk spacing.
//  - Write mode=4'b0011 in RUN: busy_o falls the next cycle, all strobes are 0. Then
//    mode=4'b0010: phase restarts at 0.
//  - Assert rst_i asynchronously mid-RUN: all outputs are 0 immediately, with no clock
//    edge required.
//  - SOUNDER_TIMESTAMP_EN, div=0, len_i=3, avg=2, from reset: ts_o holds successive dump
//    counter values 8 clks apart. Without the macro, ts_o=0 always.

Source files
------------

// File: rtl/sounder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sounder_seq_ctrl
// Brief    : Programmable sounder sequencer. Decodes the configuration bus and
//            emits chip/reference/sum/receive/dump strobes from an IDLE/RUN FSM.
//            Optional dump timestamp counter: define SOUNDER_TIMESTAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sounder_seq_ctrl #(
    parameter int         PHASE_W   = 16,
    parameter int         CHAN      = 2,
    parameter logic [6:0] BASE_ADDR = 7'd64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [6:0]         saddr_i,
    input  logic [31:0]        sdata_i,
    input  logic               s_strobe_i,
    input  logic [PHASE_W-1:0] len_i,
    output logic               reset_o,
    output logic               transmit_o,
    output logic               receive_o,
    output logic               loopback_o,
    output logic [4:0]         degree_o,
    output logic [13:0]        ampl_o,
    output logic               tx_strobe_o,
    output logic               ref_strobe_o,
    output logic               sum_strobe_o,
    output logic [CHAN-1:0]    rx_strobe_o,
    output logic               dump_strobe_o,
    output logic               busy_o,
    output logic [31:0]        ts_o
);

    localparam logic [6:0] c_addr_mode   = BASE_ADDR;
    localparam logic [6:0] c_addr_degree = BASE_ADDR + 7'd1;
    localparam logic [6:0] c_addr_ampl   = BASE_ADDR + 7'd2;
    localparam logic [6:0] c_addr_div    = BASE_ADDR + 7'd3;
    localparam logic [6:0] c_addr_avg    = BASE_ADDR + 7'd4;
    localparam logic [6:0] c_addr_chan   = BASE_ADDR + 7'd5;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [3:0]           r_mode;
    logic [4:0]           r_degree;
    logic [13:0]          r_ampl;
    logic [7:0]           r_div;
    logic [15:0]          r_avg;
    logic [CHAN-1:0]      r_chan_en;
    logic [4:0]           r_degree_act;
    logic [7:0]           r_div_act;
    logic [15:0]          r_avg_act;
    logic [7:0]           r_div_cnt;
    logic [PHASE_W-1:0]   r_phase;
    logic [15:0]          r_per_cnt;
    logic [CHAN-1:0]      r_rx;

    logic                 w_enable;
    logic                 w_run;
    logic                 w_tx;
    logic                 w_last;
    logic                 w_sum;
    logic                 w_dump;
    logic [15:0]          w_avg_eff;
    logic [15:0]          w_per_next;
    logic                 w_unused_sdata;

    assign w_unused_sdata = ^sdata_i[31:16];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mode    <= '0;
            r_degree  <= '0;
            r_ampl    <= '0;
            r_div     <= '0;
            r_avg     <= '0;
            r_chan_en <= '0;
        end else if (s_strobe_i) begin
            case (saddr_i)
                c_addr_mode:   r_mode    <= sdata_i[3:0];
                c_addr_degree: r_degree  <= sdata_i[4:0];
                c_addr_ampl:   r_ampl    <= sdata_i[13:0];
                c_addr_div:    r_div     <= sdata_i[7:0];
                c_addr_avg:    r_avg     <= sdata_i[15:0];
                c_addr_chan:   r_chan_en <= sdata_i[CHAN-1:0];
                default:       ;
            endcase
        end
    end

    // Strobes are gated by the live mode so a stop request silences them at once.
    assign w_enable   = (r_mode[1] | r_mode[2]) & ~r_mode[0];
    assign w_run      = (r_state == S_RUN) & w_enable;
    assign w_tx       = w_run & (r_div_cnt == r_div_act);
    assign w_last     = (r_phase == len_i);
    assign w_sum      = w_tx & w_last;
    assign w_avg_eff  = (r_avg_act == 16'd0) ? 16'd1 : r_avg_act;
    assign w_per_next = r_per_cnt + 16'd1;
    assign w_dump     = w_sum & (w_per_next >= w_avg_eff);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_degree_act <= '0;
            r_div_act    <= '0;
            r_avg_act    <= '0;
            r_div_cnt    <= '0;
            r_phase      <= '0;
            r_per_cnt    <= '0;
            r_rx         <= '0;
        end else begin
            r_rx <= w_sum ? r_chan_en : '0;
            case (r_state)
                S_IDLE: begin
                    r_div_cnt <= '0;
                    r_phase   <= '0;
                    r_per_cnt <= '0;
                    if (w_enable) begin
                        r_state      <= S_RUN;
                        r_degree_act <= r_degree;
                        r_div_act    <= r_div;
                        r_avg_act    <= r_avg;
                    end
                end
                S_RUN: begin
                    if (!w_enable) begin
                        r_state   <= S_IDLE;
                        r_div_cnt <= '0;
                        r_phase   <= '0;
                        r_per_cnt <= '0;
                    end else begin
                        r_div_cnt <= w_tx ? 8'd0 : r_div_cnt + 8'd1;
                        if (w_sum) begin
                            r_phase      <= '0;
                            r_degree_act <= r_degree;
                            r_div_act    <= r_div;
                            r_avg_act    <= r_avg;
                        end else if (w_tx) begin
                            r_phase <= r_phase + PHASE_W'(1);
                        end
                        if (w_dump) begin
                            r_per_cnt <= '0;
                        end else if (w_sum) begin
                            r_per_cnt <= w_per_next;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SOUNDER_TIMESTAMP_EN
    logic [31:0] r_ts_cnt;
    logic [31:0] r_ts;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ts_cnt <= '0;
            r_ts     <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 32'd1;
            if (w_dump) begin
                r_ts <= r_ts_cnt;
            end
        end
    end

    assign ts_o = r_ts;
`else
    assign ts_o = 32'h0;
`endif

    assign reset_o       = r_mode[0];
    assign transmit_o    = r_mode[1];
    assign receive_o     = r_mode[2];
    assign loopback_o    = r_mode[3];
    assign degree_o      = r_degree_act;
    assign ampl_o        = r_ampl;
    assign tx_strobe_o   = w_tx;
    assign ref_strobe_o  = w_tx & ~w_last;
    assign sum_strobe_o  = w_sum;
    assign rx_strobe_o   = r_rx;
    assign dump_strobe_o = w_dump;
    assign busy_o        = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_sounder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sounder_seq_ctrl
// Brief    : Directed bench for sounder_seq_ctrl with a strobe scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sounder_seq_ctrl;

    localparam int PHASE_W = 16;
    localparam int CHAN    = 2;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [6:0]         saddr_i;
    logic [31:0]        sdata_i;
    logic               s_strobe_i;
    logic [PHASE_W-1:0] len_i;
    logic               reset_o, transmit_o, receive_o, loopback_o;
    logic [4:0]         degree_o;
    logic [13:0]        ampl_o;
    logic               tx_strobe_o, ref_strobe_o, sum_strobe_o, dump_strobe_o, busy_o;
    logic [CHAN-1:0]    rx_strobe_o;
    logic [31:0]        ts_o;

    sounder_seq_ctrl #(.PHASE_W(PHASE_W), .CHAN(CHAN), .BASE_ADDR(7'd64)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .saddr_i      (saddr_i),
        .sdata_i      (sdata_i),
        .s_strobe_i   (s_strobe_i),
        .len_i        (len_i),
        .reset_o      (reset_o),
        .transmit_o   (transmit_o),
        .receive_o    (receive_o),
        .loopback_o   (loopback_o),
        .degree_o     (degree_o),
        .ampl_o       (ampl_o),
        .tx_strobe_o  (tx_strobe_o),
        .ref_strobe_o (ref_strobe_o),
        .sum_strobe_o (sum_strobe_o),
        .rx_strobe_o  (rx_strobe_o),
        .dump_strobe_o(dump_strobe_o),
        .busy_o       (busy_o),
        .ts_o         (ts_o)
    );

    always #5 clk_i = ~clk_i;

    int              cyc = 0;
    int              n_chk = 0;
    int              n_err = 0;
    int              tx_cnt = 0;
    int              ref_cnt = 0;
    int              last_tx = -1;
    int              q_sum[$];
    int              q_dump[$];
    int              q_rx_cyc[$];
    logic [CHAN-1:0] q_rx_val[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts posedges and compares each observed strobe against the queued expectation.
    task automatic monitor();
        int              e;
        logic [CHAN-1:0] ev;
        forever begin
            @(posedge clk_i);
            cyc++;
            #1;
            if (tx_strobe_o) begin
                tx_cnt++;
                last_tx = cyc;
            end
            if (ref_strobe_o) ref_cnt++;
            if (sum_strobe_o) begin
                e = (q_sum.size() > 0) ? q_sum.pop_front() : -1;
                chk("sum_cycle", 32'(cyc), 32'(e));
            end
            if (dump_strobe_o) begin
                e = (q_dump.size() > 0) ? q_dump.pop_front() : -1;
                chk("dump_cycle", 32'(cyc), 32'(e));
            end
            if (rx_strobe_o != '0) begin
                e  = (q_rx_cyc.size() > 0) ? q_rx_cyc.pop_front() : -1;
                ev = (q_rx_val.size() > 0) ? q_rx_val.pop_front() : '0;
                chk("rx_cycle", 32'(cyc), 32'(e));
                chk("rx_value", 32'(rx_strobe_o), 32'(ev));
            end
        end
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        saddr_i    = 7'd64 + {4'd0, off};
        sdata_i    = d;
        s_strobe_i = 1'b1;
        @(negedge clk_i);
        s_strobe_i = 1'b0;
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) @(negedge clk_i);
    endtask

    task automatic push_evt(input int first, input int step, input int n, input logic [CHAN-1:0] rxv,
                            input int dump_every);
        for (int k = 0; k < n; k++) begin
            q_sum.push_back(first + k * step);
            if ((k + 1) % dump_every == 0) q_dump.push_back(first + k * step);
            if (rxv != '0) begin
                q_rx_cyc.push_back(first + k * step + 1);
                q_rx_val.push_back(rxv);
            end
        end
    endtask

    int t0, t1, c_rel, tx_a, ref_a, ts1, ts2;

    initial begin
        rst_i      = 1'b1;
        saddr_i    = '0;
        sdata_i    = '0;
        s_strobe_i = 1'b0;
        len_i      = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_mode", 32'({loopback_o, receive_o, transmit_o, reset_o}), 32'd0);
        chk("rst_strobes", 32'({tx_strobe_o, ref_strobe_o, sum_strobe_o, dump_strobe_o}), 32'd0);
        chk("rst_rx", 32'(rx_strobe_o), 32'd0);
        chk("rst_degree", 32'(degree_o), 32'd0);
        chk("rst_ampl", 32'(ampl_o), 32'd0);
        chk("rst_ts", ts_o, 32'd0);
        rst_i = 1'b0;

        // Half-rate chips, 7-chip period, dump on every period.
        len_i = 16'd6;
        wr(3'd3, 32'd1);
        wr(3'd4, 32'd1);
        wr(3'd5, 32'd3);
        wr(3'd1, 32'd7);
        wr(3'd2, 32'hFFFF_1ABC);
        chk("ampl_immediate", 32'(ampl_o), 32'h1ABC);
        chk("degree_shadow_idle", 32'(degree_o), 32'd0);
        wr(3'd0, 32'hFFFF_FFF2);
        t0 = cyc;
        chk("mode_bits", 32'({loopback_o, receive_o, transmit_o, reset_o}), 32'b0010);
        push_evt(t0 + 14, 14, 3, 2'b11, 1);
        to_cyc(t0 + 1);
        chk("busy_run", 32'(busy_o), 32'd1);
        chk("degree_on_entry", 32'(degree_o), 32'd7);
        to_cyc(t0 + 14);
        tx_a  = tx_cnt;
        ref_a = ref_cnt;
        to_cyc(t0 + 28);
        chk("tx_per_period", 32'(tx_cnt - tx_a), 32'd7);
        chk("ref_per_period", 32'(ref_cnt - ref_a), 32'd6);
        wr(3'd1, 32'd9);
        chk("degree_held_midperiod", 32'(degree_o), 32'd7);
        to_cyc(t0 + 43);
        chk("degree_after_sum", 32'(degree_o), 32'd9);
        wr(3'd0, 32'd0);
        to_cyc(t0 + 45);
        chk("busy_stop", 32'(busy_o), 32'd0);

        // Full rate, sum every clock, dump every third, channel 1 only.
        len_i = 16'd0;
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd3);
        wr(3'd5, 32'd2);
        wr(3'd0, 32'd2);
        t0 = cyc;
        push_evt(t0 + 1, 1, 9, 2'b10, 3);
        to_cyc(t0 + 9);
        wr(3'd0, 32'd0);
        to_cyc(t0 + 12);

        // Divider change mid-period, stop via reset bit, restart.
        len_i = 16'd9;
        wr(3'd3, 32'd1);
        wr(3'd4, 32'd1);
        wr(3'd5, 32'd1);
        wr(3'd0, 32'd2);
        t0 = cyc;
        q_sum.push_back(t0 + 20);  q_dump.push_back(t0 + 20);
        q_rx_cyc.push_back(t0 + 21); q_rx_val.push_back(2'b01);
        q_sum.push_back(t0 + 70);  q_dump.push_back(t0 + 70);
        q_rx_cyc.push_back(t0 + 71); q_rx_val.push_back(2'b01);
        to_cyc(t0 + 6);
        wr(3'd3, 32'd4);
        to_cyc(t0 + 25);
        chk("first_chip_new_div", 32'(last_tx), 32'(t0 + 25));
        to_cyc(t0 + 74);
        wr(3'd0, 32'd3);
        chk("stop_busy_still", 32'(busy_o), 32'd1);
        chk("stop_tx_gated", 32'(tx_strobe_o), 32'd0);
        to_cyc(t0 + 76);
        chk("stop_busy_fall", 32'(busy_o), 32'd0);
        chk("stop_last_tx", 32'(last_tx), 32'(t0 + 70));
        wr(3'd0, 32'd2);
        t1 = cyc;
        q_sum.push_back(t1 + 50);  q_dump.push_back(t1 + 50);
        q_rx_cyc.push_back(t1 + 51); q_rx_val.push_back(2'b01);
        to_cyc(t1 + 5);
        chk("restart_first_chip", 32'(last_tx), 32'(t1 + 5));
        to_cyc(t1 + 51);
        wr(3'd0, 32'd0);
        to_cyc(t1 + 54);

        // Asynchronous reset in the middle of a run.
        len_i = 16'd0;
        wr(3'd3, 32'd0);
        wr(3'd0, 32'd2);
        t0 = cyc;
        push_evt(t0 + 1, 1, 4, 2'b01, 1);
        void'(q_rx_cyc.pop_back());
        void'(q_rx_val.pop_back());
        to_cyc(t0 + 4);
        chk("pre_reset_sum", 32'(sum_strobe_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_busy", 32'(busy_o), 32'd0);
        chk("async_strobes", 32'({tx_strobe_o, ref_strobe_o, sum_strobe_o, dump_strobe_o}), 32'd0);
        chk("async_rx", 32'(rx_strobe_o), 32'd0);
        chk("async_mode", 32'({loopback_o, receive_o, transmit_o, reset_o}), 32'd0);
        chk("async_ampl", 32'(ampl_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        c_rel = cyc;

        // Dump timestamps: four-chip periods, two periods per dump.
        len_i = 16'd3;
        wr(3'd4, 32'd2);
        wr(3'd0, 32'd2);
        t0 = cyc;
        push_evt(t0 + 4, 4, 4, 2'b00, 2);
        to_cyc(t0 + 9);
        ts1 = int'(ts_o);
        to_cyc(t0 + 17);
        ts2 = int'(ts_o);
`ifdef SOUNDER_TIMESTAMP_EN
        chk("ts_first", 32'(ts1), 32'(t0 + 8 - c_rel));
        chk("ts_spacing", 32'(ts2 - ts1), 32'd8);
`else
        chk("ts_tied_first", 32'(ts1), 32'd0);
        chk("ts_tied_second", 32'(ts2), 32'd0);
`endif
        wr(3'd0, 32'd0);
        repeat (4) @(negedge clk_i);
        chk("sum_queue_empty", 32'(q_sum.size()), 32'd0);
        chk("dump_queue_empty", 32'(q_dump.size()), 32'd0);
        chk("rx_queue_empty", 32'(q_rx_cyc.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
